seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Downstream consumer of the Nios system's 28-bit decode and period exports.
- Takes four packed 7-segment patterns (decode word) and a per-digit dwell time in clock cycles (period word).
- Time-multiplexes them onto a 4-digit common-anode scanned display, inserting an anti-ghosting blank gap before each digit.
- Both inputs are shadow-latched at frame boundaries, so software writes never tear a frame.

Parameters:
DIGITS, 4, number of scanned digits
SEG_W, 7, segments per digit (bit0 = segment a … bit6 = segment g)
PERIOD_W, 28, width of period input
BLANK_CYCLES, 16, cycles all digits are off at the start of each digit slot
MIN_PERIOD, 32, minimum effective slot length; nonzero periods below this are clamped up (must be > BLANK_CYCLES)

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  asynchronous, active-high reset
decode_in  in  DIGITS*SEG_W (28)  segment patterns, 1 = segment lit; digit k in bits [k*7+6:k*7]
period_in  in  PERIOD_W (28)  slot length in clocks per digit; 0 = display disabled
seg_n  out  SEG_W  segment drive, active-low
dig_n  out  DIGITS  digit enable, active-low, at most one low at any time
frame_tick  out  1  one-cycle pulse on the first cycle of each frame

Behaviour:
- Reset asserted (asynchronous): state=IDLE, digit index=0, slot counter=0, shadow decode/period=0. Outputs: seg_n=all 1, dig_n=all 1, frame_tick=0. Outputs take these values immediately, without waiting for a clock edge.
- All outputs are registered and change on the same edge as the state register. In SHOW, dig_n/seg_n reflect the current digit that same cycle.
- Effective period: p_eff = (period_sh < MIN_PERIOD) ? MIN_PERIOD : period_sh, applied only when period_sh != 0. Comparison is unsigned, full PERIOD_W.
- States:
  - IDLE: all outputs off. Every cycle, load both shadows from inputs. If the loaded period_in != 0, the next state is BLANK with digit 0, counter 0, and frame_tick=1 in that first BLANK cycle.
  - BLANK: dig_n all 1, seg_n all 1. The counter increments. When counter == BLANK_CYCLES-1, go to SHOW.
  - SHOW: dig_n has bit[idx] low and the rest high. seg_n = ~decode_sh[idx]. The counter increments. When counter == p_eff-1, the slot ends:
    - If idx < DIGITS-1: idx+1, counter 0, go to BLANK.
    - If idx == DIGITS-1 (frame boundary): reload both shadows from inputs.
      - If the new period is 0, go to IDLE.
      - Otherwise go to BLANK with idx 0, counter 0, frame_tick=1 in that cycle.
- Each slot lasts exactly p_eff cycles: BLANK_CYCLES blank, then p_eff-BLANK_CYCLES lit. A frame lasts DIGITS*p_eff cycles. frame_tick period = DIGITS*p_eff.
- Input changes mid-frame have no effect until the next frame boundary. This covers period going to 0 mid-frame: the frame completes, then the block enters IDLE.
- The counter is PERIOD_W bits wide and never wraps, because it resets at slot end and p_eff ≤ 2^28-1.
- Reset mid-operation aborts the frame. After release, the block restarts from IDLE and reaches the first BLANK two edges later.

Test Plan (BLANK_CYCLES=2, MIN_PERIOD=4):
- Reset held with period_in=10 → seg_n=7'h7F, dig_n=4'hF, frame_tick=0. Release → frame_tick on 2nd edge, dig_n stays 4'hF for 2 cycles.
- period_in=10, decode_in={7'h4F,7'h5B,7'h06,7'h3F} → per digit: 2 blank cycles, then 8 cycles with dig_n=1110/1101/1011/0111 and seg_n=7'h40/7'h79/7'h24/7'h30. frame_tick every 40 cycles.
- Change period_in 10→20 at cycle 15 of a frame → remaining slots of that frame stay 10 cycles. The next frame uses 20-cycle slots and the tick spacing becomes 80.
- period_in=1 → clamped: each slot is 2 blank + 2 lit, frame 16 cycles. period_in=4 gives the identical result.
- Set period_in=0 mid-frame → the frame finishes, then all outputs stay off and no ticks occur. Restore 10 → frame_tick within 2 cycles, digit 0 shown after 2 blank cycles.
- Assert reset_reset asynchronously mid-SHOW (between clock edges) → seg_n=7'h7F and dig_n=4'hF immediately, before the next edge.

Source files
------------

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - 4-digit common-anode scan driver with blank gap and frame-boundary shadowing
module seg_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int SEG_W        = 7,
  parameter int PERIOD_W     = 28,
  parameter int BLANK_CYCLES = 16,
  parameter int MIN_PERIOD   = 32
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset,
  input  logic [DIGITS*SEG_W-1:0]   decode_in,
  input  logic [PERIOD_W-1:0]       period_in,
  output logic [SEG_W-1:0]          seg_n,
  output logic [DIGITS-1:0]         dig_n,
  output logic                      frame_tick
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PERIOD_W-1:0] MIN_P      = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] BLANK_LAST = PERIOD_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [PERIOD_W-1:0]       cnt_q, cnt_d;
  logic [DIGITS*SEG_W-1:0]   decode_sh, decode_sh_d;
  logic [PERIOD_W-1:0]       period_sh, period_sh_d;
  logic [SEG_W-1:0]          seg_d;
  logic [DIGITS-1:0]         dig_d;
  logic                      tick_d;
  logic [PERIOD_W-1:0]       p_eff;
  logic [PERIOD_W-1:0]       slot_last;

  // Short nonzero periods are stretched so the lit part of a slot never vanishes.
  assign p_eff     = (period_sh < MIN_P) ? MIN_P : period_sh;
  assign slot_last = p_eff - PERIOD_W'(1);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    decode_sh_d = decode_sh;
    period_sh_d = period_sh;
    tick_d      = 1'b0;
    seg_d       = '1;
    dig_d       = '1;

    case (state_q)
      IDLE: begin
        idx_d = '0;
        cnt_d = '0;
        // Shadows freeze on the transition edge so the frame starts with what was tested.
        if (period_sh != '0) begin
          state_d = BLANK;
          tick_d  = 1'b1;
        end else begin
          decode_sh_d = decode_in;
          period_sh_d = period_in;
        end
      end
      BLANK: begin
        cnt_d = cnt_q + PERIOD_W'(1);
        if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
        end
      end
      SHOW: begin
        cnt_d = cnt_q + PERIOD_W'(1);
        if (cnt_q == slot_last) begin
          cnt_d = '0;
          if (idx_q != LAST_IDX) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = BLANK;
          end else begin
            idx_d       = '0;
            decode_sh_d = decode_in;
            period_sh_d = period_in;
            if (period_in == '0) begin
              state_d = IDLE;
            end else begin
              state_d = BLANK;
              tick_d  = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered, so they are derived from the next-state values.
    if (state_d == SHOW) begin
      dig_d = ~(DIGITS'(1) << idx_d);
      seg_d = ~decode_sh_d[32'(idx_d)*SEG_W +: SEG_W];
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      decode_sh  <= '0;
      period_sh  <= '0;
      seg_n      <= '1;
      dig_n      <= '1;
      frame_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      decode_sh  <= decode_sh_d;
      period_sh  <= period_sh_d;
      seg_n      <= seg_d;
      dig_n      <= dig_d;
      frame_tick <= tick_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - scoreboard bench for seg_scan_driver with BLANK_CYCLES=2, MIN_PERIOD=4
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [27:0] decode_in;
  logic [27:0] period_in;
  logic [6:0]  seg_n;
  logic [3:0]  dig_n;
  logic        frame_tick;

  int errors = 0;
  int checks = 0;
  int mon_cyc = 0;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] dig;
    logic       tick;
  } rec_t;

  rec_t exp_q[$];

  // Digits 0..3 of D1 = 3F,06,5B,4F -> lit seg_n 40,79,24,30
  localparam logic [27:0] D1 = {7'h4F, 7'h5B, 7'h06, 7'h3F};
  // Digits 0..3 of D2 = 66,6D,7D,07 -> lit seg_n 19,12,02,78
  localparam logic [27:0] D2 = {7'h07, 7'h7D, 7'h6D, 7'h66};

  seg_scan_driver #(
    .DIGITS(4), .SEG_W(7), .PERIOD_W(28), .BLANK_CYCLES(2), .MIN_PERIOD(4)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .decode_in   (decode_in),
    .period_in   (period_in),
    .seg_n       (seg_n),
    .dig_n       (dig_n),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic push_off(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({7'h7F, 4'hF, 1'b0});
  endtask

  // First n cycles of a frame with slot length p and the given lit patterns.
  task automatic push_frame(input int p, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3, input int n);
    logic [6:0] segs [4];
    logic [3:0] digs [4];
    segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
    digs[0] = 4'b1110; digs[1] = 4'b1101; digs[2] = 4'b1011; digs[3] = 4'b0111;
    for (int c = 0; c < n; c++) begin
      int slot;
      int off;
      slot = c / p;
      off  = c % p;
      if (off < 2) exp_q.push_back({7'h7F, 4'hF, (c == 0)});
      else         exp_q.push_back({segs[slot], digs[slot], 1'b0});
    end
  endtask

  task automatic check_now(input string name, input rec_t got, input rec_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: seg_n=%h dig_n=%b frame_tick=%b, expected seg_n=%h dig_n=%b frame_tick=%b",
               name, got.seg, got.dig, got.tick, want.seg, want.dig, want.tick);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      rec_t e;
      rec_t a;
      e = exp_q.pop_front();
      a = {seg_n, dig_n, frame_tick};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL stream cyc%0d: seg_n=%h dig_n=%b frame_tick=%b, expected seg_n=%h dig_n=%b frame_tick=%b",
                 mon_cyc, a.seg, a.dig, a.tick, e.seg, e.dig, e.tick);
      end
      mon_cyc++;
    end
  end

  initial begin
    rst       = 1'b1;
    period_in = 28'd10;
    decode_in = D1;

    push_off(4);                                           // 3 in reset + IDLE load edge
    push_frame(10, 7'h40, 7'h79, 7'h24, 7'h30, 40);        // frame 1
    push_frame(10, 7'h40, 7'h79, 7'h24, 7'h30, 40);        // frame 2, period change mid-frame
    push_frame(20, 7'h40, 7'h79, 7'h24, 7'h30, 80);        // frame 3, decode change mid-frame
    push_frame(4,  7'h19, 7'h12, 7'h02, 7'h78, 16);        // period 1 clamped to 4
    push_frame(4,  7'h19, 7'h12, 7'h02, 7'h78, 16);        // period 4 identical
    push_off(11);                                          // idle while period 0, then reload edge
    push_frame(10, 7'h40, 7'h79, 7'h24, 7'h30, 5);         // aborted by reset at cycle 5
    push_off(3);

    #1;
    check_now("reset_state", {seg_n, dig_n, frame_tick}, {7'h7F, 4'hF, 1'b0});

    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    edges(57);  period_in = 28'd20;                        // frame 2 cycle 15
    edges(55);  period_in = 28'd1; decode_in = D2;         // frame 3 cycle 30
    edges(53);  period_in = 28'd4;                         // frame 4 cycle 3
    edges(18);  period_in = 28'd0;                         // frame 5 cycle 5
    edges(20);  period_in = 28'd10; decode_in = D1;        // after 10 idle cycles

    repeat (7) @(posedge clk);
    #3 rst = 1'b1;                                         // mid-SHOW of digit 0
    #1 check_now("async_reset", {seg_n, dig_n, frame_tick}, {7'h7F, 4'hF, 1'b0});

    edges(3);
    for (int g = 0; g < 50 && exp_q.size() > 0; g++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected cycles left unchecked, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
